// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner
//   Scans a 4x4 active-low hex keypad one column at a time, debounces the
//   full-scan result, and reports each accepted keypress as a 4-bit code
//   with a one-cycle strobe. Alternate strobes load operand nibbles a and b.
//
//   Optional feature macro: KEYPAD_AUTOREPEAT_EN
//     defined   -> a held key re-strobes every REPEAT_SCANS full scans
//     undefined -> exactly one strobe per press
//
// Ports
//   clk       system clock
//   clr       asynchronous active-low reset
//   row[3:0]  keypad rows, active-low, asynchronous to clk
//   col[3:0]  keypad column drive, active-low one-hot
//   key[3:0]  code of the last accepted key (4*row + col)
//   key_valid one-cycle strobe for a new or repeated key
//   key_held  high while the accepted key is debounced-pressed
//   a[3:0]    operand A
//   b[3:0]    operand B
//   sel       next operand target (0 = a, 1 = b)
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int REPEAT_SCANS   = 250
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic       sel
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_MAX  = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_kind_t;

  typedef struct packed {
    res_kind_t  kind;
    logic [3:0] code;
  } scan_res_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  // Reject parameter values the scan timing cannot support.
  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be at least 1");
  end
  if (REPEAT_SCANS < 1) begin : g_bad_repeat
    $error("REPEAT_SCANS must be at least 1");
  end

  // Active-low one-hot column drive for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    case (idx)
      2'd0:    col_drive = 4'b1110;
      2'd1:    col_drive = 4'b1101;
      2'd2:    col_drive = 4'b1011;
      2'd3:    col_drive = 4'b0111;
      default: col_drive = 4'b1110;
    endcase
  endfunction

  logic [3:0]    row_meta_r, row_sync_r;
  logic [DW-1:0] div_r;
  logic          tick_s, scan_done_s;
  logic [1:0]    col_idx_r;
  logic [3:0]    col_r;
  logic [15:0]   hits_r, matrix_s;
  logic [4:0]    n_hits_s;
  logic [3:0]    code_s;
  scan_res_t     result_s, prev_r;
  logic [CW-1:0] deb_cnt_r, deb_nx_s;
  logic          stable_s;
  state_t        state_r, state_nx;
  logic [3:0]    key_r, key_nx, a_r, a_nx, b_r, b_nx;
  logic          held_r, held_nx, sel_r, sel_nx, strobe_s, key_valid_r;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_SCANS);
  logic [RW-1:0] rep_r, rep_nx;
`endif

  assign tick_s      = (div_r == DIV_LAST);
  assign scan_done_s = tick_s && (col_idx_r == 2'd3);

  // Two-flop synchronizer for the asynchronous row lines (idle high).
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // Column dwell divider, column index and registered column drive.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_r     <= '0;
      col_idx_r <= 2'd0;
      col_r     <= 4'b1110;
    end else if (tick_s) begin
      div_r     <= '0;
      col_idx_r <= col_idx_r + 2'd1;
      col_r     <= col_drive(col_idx_r + 2'd1);
    end else begin
      div_r <= div_r + DW'(1);
    end
  end

  // Record the pressed intersections of the active column at each tick.
  // Bit index is 4*row + col, i.e. the key code.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hits_r <= '0;
    end else if (tick_s) begin
      for (int r = 0; r < 4; r++) begin
        hits_r[{2'(r), col_idx_r}] <= ~row_sync_r[r];
      end
    end
  end

  // Full keypad matrix: stored columns 0..2 plus the live column-3 sample.
  always_comb begin
    matrix_s = hits_r;
    for (int r = 0; r < 4; r++) begin
      matrix_s[{2'(r), 2'd3}] = ~row_sync_r[r];
    end
  end

  // Classify the matrix as NONE, SINGLE(code) or MULTI.
  always_comb begin
    n_hits_s = 5'd0;
    code_s   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      n_hits_s = n_hits_s + {4'd0, matrix_s[i]};
      if (matrix_s[i]) begin
        code_s = 4'(i);
      end else begin
        code_s = code_s;
      end
    end
    case (n_hits_s)
      5'd0:    result_s = '{kind: RES_NONE,   code: 4'd0};
      5'd1:    result_s = '{kind: RES_SINGLE, code: code_s};
      default: result_s = '{kind: RES_MULTI,  code: 4'd0};
    endcase
  end

  // Next debounce count: run length of identical results, saturating.
  always_comb begin
    if (result_s == prev_r) begin
      if (deb_cnt_r == DEB_MAX) begin
        deb_nx_s = DEB_MAX;
      end else begin
        deb_nx_s = deb_cnt_r + CW'(1);
      end
    end else begin
      deb_nx_s = CW'(1);
    end
    stable_s = (deb_nx_s == DEB_MAX);
  end

  // Debounce counter and previous-result register, updated per full scan.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      deb_cnt_r <= '0;
      prev_r    <= '{kind: RES_NONE, code: 4'd0};
    end else if (scan_done_s) begin
      deb_cnt_r <= deb_nx_s;
      prev_r    <= result_s;
    end
  end

  // Press/release FSM; a different key while pressed is ignored until NONE.
  always_comb begin
    state_nx = state_r;
    key_nx   = key_r;
    held_nx  = held_r;
    strobe_s = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_nx   = rep_r;
`endif
    if (scan_done_s) begin
      case (state_r)
        ST_IDLE: begin
          if ((result_s.kind == RES_SINGLE) && stable_s) begin
            state_nx = ST_PRESSED;
            key_nx   = result_s.code;
            held_nx  = 1'b1;
            strobe_s = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_nx   = '0;
`endif
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if ((result_s.kind == RES_NONE) && stable_s) begin
            state_nx = ST_IDLE;
            held_nx  = 1'b0;
          end else begin
            state_nx = ST_PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
            // Only an uninterrupted hold of the accepted key advances the count.
            if ((result_s.kind == RES_SINGLE) && (result_s.code == key_r)) begin
              if ((rep_r + RW'(1)) == REP_MAX) begin
                strobe_s = 1'b1;
                rep_nx   = '0;
              end else begin
                rep_nx = rep_r + RW'(1);
              end
            end else begin
              rep_nx = '0;
            end
`endif
          end
        end
        default: begin
          state_nx = ST_IDLE;
          held_nx  = 1'b0;
        end
      endcase
    end else begin
      state_nx = state_r;
    end
  end

  // Operand latch: each strobe writes the key to the selected nibble.
  always_comb begin
    a_nx   = a_r;
    b_nx   = b_r;
    sel_nx = sel_r;
    if (strobe_s) begin
      if (sel_r) begin
        b_nx = key_nx;
      end else begin
        a_nx = key_nx;
      end
      sel_nx = ~sel_r;
    end else begin
      sel_nx = sel_r;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r     <= ST_IDLE;
      key_r       <= 4'd0;
      held_r      <= 1'b0;
      key_valid_r <= 1'b0;
      a_r         <= 4'd0;
      b_r         <= 4'd0;
      sel_r       <= 1'b0;
    end else begin
      state_r     <= state_nx;
      key_r       <= key_nx;
      held_r      <= held_nx;
      key_valid_r <= strobe_s;
      a_r         <= a_nx;
      b_r         <= b_nx;
      sel_r       <= sel_nx;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Auto-repeat scan counter.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rep_r <= '0;
    end else begin
      rep_r <= rep_nx;
    end
  end
`endif

  assign col       = col_r;
  assign key       = key_r;
  assign key_valid = key_valid_r;
  assign key_held  = held_r;
  assign a         = a_r;
  assign b         = b_r;
  assign sel       = sel_r;

endmodule

// File: doc/hex_keypad_scanner.md
# hex_keypad_scanner

Scans a 4x4 matrix hex keypad, debounces it, and reports each new keypress as a 4-bit hex code with a one-cycle strobe. Alternate keypresses are latched into two operand nibbles, `a` and `b`. The block is the input-side counterpart of the four-digit seven-segment display path: it supplies the addend nibbles to the adder top level in place of slide switches.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each column is driven before the rows are sampled. Minimum 4.
- `DEBOUNCE_SCANS`, default 8: consecutive identical full-scan results required to accept a press or a release. Minimum 1.
- `REPEAT_SCANS`, default 250: full scans between auto-repeat strobes. Used only with `KEYPAD_AUTOREPEAT_EN`.
- `clk` input 1: system clock. The block uses this single clock only.
- `clr` input 1: reset, asynchronous, active-low.
- `row` input 4: keypad row lines, active-low, pulled up externally; asynchronous to `clk`.
- `col` output 4: keypad column drive, active-low, exactly one bit low at all times.
- `key` output 4: code of the last accepted key.
- `key_valid` output 1: one-cycle strobe, asserted when `key` is new or repeated.
- `key_held` output 1: high while the accepted key is debounced-pressed.
- `a` output 4: operand A.
- `b` output 4: operand B.
- `sel` output 1: next operand target, 0 = `a`, 1 = `b`.

## Operation
- **Row synchronizer:** `row` passes through a 2-flop synchronizer. All decoding uses the synchronized value.
- **Column scan:** a divider counts 0..`SCAN_DIV`-1. On terminal count ("tick"):
  - the synchronized rows for the active column are recorded;
  - the column index advances 0→1→2→3→0;
  - `col` is the active-low one-hot of the index (col0 = 4'b1110).
- **Full-scan result:** produced on the tick that samples column 3. It is one of:
  - NONE: no row low in any column;
  - SINGLE(code): exactly one row/column intersection low, code = 4*row + col;
  - MULTI: two or more intersections low.
- **Debounce:** the counter increments when the current result equals the previous one, otherwise it reloads to 1. It saturates at `DEBOUNCE_SCANS`.
- **FSM:**
  - IDLE → PRESSED when the result is SINGLE(k) and the count reaches `DEBOUNCE_SCANS`. Actions: `key`←k, pulse `key_valid`, set `key_held`.
  - IDLE ignores NONE and MULTI.
  - PRESSED → IDLE when the result is NONE and the count reaches `DEBOUNCE_SCANS`. Action: clear `key_held`.
  - In PRESSED, MULTI and any SINGLE (same or different key) keep the state. A different key produces no strobe; it must be released to NONE first.
- **Operand latch:** on each `key_valid`, `key` is written to `a` if `sel`=0, else to `b`. `sel` then toggles.

## Timing
- Reset values (while `clr`=0):
  - `col`=4'b1110, `key`=0, `key_valid`=0, `key_held`=0, `a`=0, `b`=0, `sel`=0;
  - divider, column index, debounce counter and repeat counter = 0;
  - previous result = NONE; FSM = IDLE.
- Reset takes effect immediately, including mid-scan or mid-debounce. After reset, scanning restarts at column 0 and a full new debounce is required.
- `key_valid` is registered. It is high the cycle after the column-3 tick that completes debounce; `key`, `key_held`, `a`/`b` and `sel` update in that same cycle.
- Press latency, from a stable press to `key_valid`: at most (`DEBOUNCE_SCANS`+1)·4·`SCAN_DIV` + 3 cycles.
- `key_valid` is never high on two consecutive cycles.
- A press shorter than `DEBOUNCE_SCANS` full scans produces no strobe.
- The divider, column index and all counters wrap or saturate without glitches. `col` changes only on the cycle after a tick.

## Configuration
- **`KEYPAD_AUTOREPEAT_EN` defined:** a repeat counter clears on entry to PRESSED and increments on each full scan that is SINGLE with the accepted code. When it reaches `REPEAT_SCANS`, the block pulses `key_valid` with the unchanged `key`, the operand latch writes and `sel` toggles, and the counter clears. MULTI, NONE or a different code clear the counter without a strobe.
- **`KEYPAD_AUTOREPEAT_EN` not defined:** the repeat logic is absent and exactly one strobe is produced per press.

## Test plan
Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=2, `REPEAT_SCANS`=3, and a keypad model that pulls `row[r]` low when `col[c]` is low.
- **Reset:** `clr` low mid-scan → `col`=4'b1110, `a`=`b`=0, `sel`=0, `key_valid`=0, all immediately.
- **Single press:** press row 2 / col 1 for 6 scans → exactly one `key_valid` with `key`=9, then `a`=9, `sel`=1, `key_held`=1. Release → `key_held`=0 after 2 NONE scans.
- **Second press:** then press row 3 / col 3 → `key`=15, `b`=15, `sel`=0, `a` still 9.
- **Bounce:** toggle key 5 every scan for 5 scans → no `key_valid`. Then hold 2 scans → one strobe with `key`=5.
- **Multi-key:** press keys 0 and 1 together from IDLE → no strobe. While key 4 is held, add key 7, then release key 4 while still holding 7 → no new strobe until full release.
- **Auto-repeat (with `KEYPAD_AUTOREPEAT_EN`):** hold key 0xA for 10 scans after acceptance → strobes at acceptance, +3, +6 and +9 scans, and `sel` toggles each time. Without the macro → a single strobe.
